// File: rtl/bfly_16_1.sv
// bfly_16_1 -- radix-2 decimation-in-frequency butterfly stage.
//
// Purpose: takes x1/x2 pairs from the 16-deep delay FIFO stage. The sum
// (x1+x2)/2 leaves immediately. The twiddled difference ((x1-x2)/2)*W^k
// goes into an internal buffer and is drained in the pair_num cycles that
// follow the last sum. The result is one contiguous 2*pair_num sample
// stream per frame.
//
// Ports:
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   data_in1       x1 (delayed sample), {re, im}, each data_len bits signed
//   data_in2       x2 (current sample), same packing
//   data_in_valid  pair valid
//   tf_addr        twiddle ROM address (current pair index k)
//   tf_data        twiddle {re, im} Q2.(tw_len-2), one cycle after tf_addr
//   data_out       output sample, {re, im}
//   data_out_valid output valid
//   data_out_sop   high with the first sum of each frame
//   overrun        sticky: a pair arrived while the differences were draining
module bfly_16_1 #(
  parameter int data_len      = 32,
  parameter int pair_num      = 16,
  parameter int pair_addr_len = 4,
  parameter int tw_len        = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*data_len-1:0]      data_in1,
  input  logic [2*data_len-1:0]      data_in2,
  input  logic                       data_in_valid,
  output logic [pair_addr_len-1:0]   tf_addr,
  input  logic [2*tw_len-1:0]        tf_data,
  output logic [2*data_len-1:0]      data_out,
  output logic                       data_out_valid,
  output logic                       data_out_sop,
  output logic                       overrun
);

  localparam int PW = data_len + tw_len;
  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] DRAIN = 1'b1;
  localparam logic [pair_addr_len-1:0] LAST = pair_addr_len'(pair_num - 1);

  logic [0:0]               state;
  logic [pair_addr_len-1:0] k;
  logic [pair_addr_len-1:0] r;

  logic signed [data_len-1:0] x1_re, x1_im, x2_re, x2_im;
  logic signed [data_len:0]   add_re, add_im, sub_re, sub_im;
  logic [2*data_len-1:0]      sum_pk, diff_pk;

  // Difference / twiddle pipeline registers
  logic [2*data_len-1:0]      d1, d2;
  logic [2*tw_len-1:0]        w2;
  logic [pair_addr_len-1:0]   k1, k2, k3;
  logic                       v1, v2, v3;
  logic signed [PW-1:0]       p_rr, p_ii, p_ri, p_ir;
  logic signed [PW:0]         acc_re, acc_im;
  logic [data_len-1:0]        tw_re, tw_im;

  logic [2*data_len-1:0]      buf_mem [pair_num];

  logic                       accept;

  // Signed product with both operands widened to the full product width
  function automatic logic signed [PW-1:0] smul(input logic signed [data_len-1:0] a,
                                                input logic signed [tw_len-1:0] b);
    logic signed [PW-1:0] ae, be;
    ae = PW'(a);
    be = PW'(b);
    return ae * be;
  endfunction

  assign x1_re = data_in1[2*data_len-1:data_len];
  assign x1_im = data_in1[data_len-1:0];
  assign x2_re = data_in2[2*data_len-1:data_len];
  assign x2_im = data_in2[data_len-1:0];

  // One guard bit keeps the sum/difference exact before the floor halving
  assign add_re = {x1_re[data_len-1], x1_re} + {x2_re[data_len-1], x2_re};
  assign add_im = {x1_im[data_len-1], x1_im} + {x2_im[data_len-1], x2_im};
  assign sub_re = {x1_re[data_len-1], x1_re} - {x2_re[data_len-1], x2_re};
  assign sub_im = {x1_im[data_len-1], x1_im} - {x2_im[data_len-1], x2_im};

  assign sum_pk  = {data_len'(add_re >>> 1), data_len'(add_im >>> 1)};
  assign diff_pk = {data_len'(sub_re >>> 1), data_len'(sub_im >>> 1)};

  assign accept  = (state == FILL) && data_in_valid;
  assign tf_addr = k;

  // Twiddle combine: wraps to data_len bits, no saturation
  assign acc_re = (PW+1)'(p_rr) - (PW+1)'(p_ii);
  assign acc_im = (PW+1)'(p_ri) + (PW+1)'(p_ir);
  assign tw_re  = data_len'(acc_re >>> (tw_len - 2));
  assign tw_im  = data_len'(acc_im >>> (tw_len - 2));

  // Frame control: sums go straight out during FILL, buffered twiddled
  // differences go out during DRAIN. Pairs arriving in DRAIN are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= FILL;
      k              <= '0;
      r              <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
      data_out_sop   <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      data_out_sop   <= 1'b0;
      case (state)
        FILL: begin
          if (data_in_valid) begin
            data_out       <= sum_pk;
            data_out_valid <= 1'b1;
            data_out_sop   <= (k == '0);
            if (k == LAST) begin
              k     <= '0;
              state <= DRAIN;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        DRAIN: begin
          data_out       <= buf_mem[r];
          data_out_valid <= 1'b1;
          if (data_in_valid) overrun <= 1'b1;
          if (r == LAST) begin
            r     <= '0;
            state <= FILL;
          end else begin
            r <= r + 1'b1;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // Pipeline valids: stage 1 holds d, stage 2 aligns d with the ROM data,
  // stage 3 holds the products, then the buffer write.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
    end else begin
      v1 <= accept;
      v2 <= v1;
      v3 <= v2;
    end
  end

  // Pipeline data path; contents are qualified by the valids above
  always_ff @(posedge clk) begin
    if (accept) begin
      d1 <= diff_pk;
      k1 <= k;
    end
    d2   <= d1;
    w2   <= tf_data;
    k2   <= k1;
    p_rr <= smul(d2[2*data_len-1:data_len], w2[2*tw_len-1:tw_len]);
    p_ii <= smul(d2[data_len-1:0],          w2[tw_len-1:0]);
    p_ri <= smul(d2[2*data_len-1:data_len], w2[tw_len-1:0]);
    p_ir <= smul(d2[data_len-1:0],          w2[2*tw_len-1:tw_len]);
    k3   <= k2;
  end

  // Difference buffer; every entry is rewritten before DRAIN reads it
  always_ff @(posedge clk) begin
    if (v3) buf_mem[k3] <= {tw_re, tw_im};
  end

endmodule

// File: tb/tb_bfly_16_1.sv
// tb_bfly_16_1 -- scoreboard bench for bfly_16_1.
// Stimulus pushes hand-computed expected outputs into a queue; a monitor on
// the falling edge pops and compares whenever data_out_valid is high.
module tb_bfly_16_1;

  logic        clk;
  logic        rst;
  logic [63:0] data_in1;
  logic [63:0] data_in2;
  logic        data_in_valid;
  logic [3:0]  tf_addr;
  logic [31:0] tf_data;
  logic [63:0] data_out;
  logic        data_out_valid;
  logic        data_out_sop;
  logic        overrun;

  int          checks;
  int          failures;
  int          cur_run;
  int          last_run;
  logic [64:0] exp_q [$];
  logic [64:0] mon_exp;
  logic [31:0] rom [16];

  bfly_16_1 dut (
    .clk            (clk),
    .rst            (rst),
    .data_in1       (data_in1),
    .data_in2       (data_in2),
    .data_in_valid  (data_in_valid),
    .tf_addr        (tf_addr),
    .tf_data        (tf_data),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_sop   (data_out_sop),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous twiddle ROM model
  always @(posedge clk) tf_data <= rom[tf_addr];

  function automatic logic [63:0] cx(input int re, input int im);
    logic [31:0] a, b;
    a = re;
    b = im;
    return {a, b};
  endfunction

  function automatic logic [31:0] tw(input int re, input int im);
    logic [15:0] a, b;
    a = re[15:0];
    b = im[15:0];
    return {a, b};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [63:0] x1, input logic [63:0] x2);
    data_in1      = x1;
    data_in2      = x2;
    data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic setTwiddle(input logic [31:0] even_w, input logic [31:0] odd_w);
    for (int j = 0; j < 16; j++) rom[j] = (j % 2 == 0) ? even_w : odd_w;
  endtask

  // One frame of 16 identical pairs; optional gap before pair 8; n_diff
  // differences are expected to appear.
  task automatic runFrame(input logic [63:0] x1, input logic [63:0] x2,
                          input logic [63:0] exp_sum, input logic [63:0] exp_de,
                          input logic [63:0] exp_do, input int gap, input int n_diff);
    for (int i = 0; i < 16; i++) begin
      if (gap > 0 && i == 8) idle(gap);
      checkOutput("tf_addr", 64'(tf_addr), 64'(i));
      exp_q.push_back({(i == 0), exp_sum});
      applyStimulus(x1, x2);
    end
    for (int i = 0; i < n_diff; i++) exp_q.push_back({1'b0, (i % 2 == 0) ? exp_de : exp_do});
  endtask

  // Monitor: pops the scoreboard and tracks contiguous valid runs
  always @(negedge clk) begin
    if (data_out_valid === 1'b1) begin
      cur_run++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_output: actual=%h expected=none at %0t", data_out, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("data_out", data_out, mon_exp[63:0]);
        checkOutput("data_out_sop", 64'(data_out_sop), 64'(mon_exp[64]));
      end
    end else begin
      if (cur_run > 0) last_run = cur_run;
      cur_run = 0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks        = 0;
    failures      = 0;
    cur_run       = 0;
    last_run      = 0;
    rst           = 1'b1;
    data_in_valid = 1'b0;
    data_in1      = '0;
    data_in2      = '0;
    setTwiddle(tw(16384, 0), tw(16384, 0));
    idle(3);
    checkOutput("reset_data_out", data_out, 64'd0);
    checkOutput("reset_valid", 64'(data_out_valid), 64'd0);
    checkOutput("reset_sop", 64'(data_out_sop), 64'd0);
    checkOutput("reset_tf_addr", 64'(tf_addr), 64'd0);
    checkOutput("reset_overrun", 64'(overrun), 64'd0);
    rst = 1'b0;
    idle(2);

    $display("[TB] basic butterfly, W=1");
    runFrame(cx(100, 0), cx(20, 0), cx(60, 0), cx(40, 0), cx(40, 0), 0, 16);
    idle(20);
    checkOutput("basic_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("basic_run", 64'(last_run), 64'd32);

    $display("[TB] twiddle -j");
    setTwiddle(tw(0, -16384), tw(0, -16384));
    runFrame(cx(100, 0), cx(20, 0), cx(60, 0), cx(0, -40), cx(0, -40), 0, 16);
    idle(20);
    checkOutput("minus_j_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] floor rounding and full-scale inputs");
    setTwiddle(tw(16384, 0), tw(16384, 0));
    runFrame(cx(-3, 5), cx(0, 0), cx(-2, 2), cx(-2, 2), cx(-2, 2), 0, 16);
    idle(20);
    runFrame(cx(32'h7FFFFFFF, 32'h80000000), cx(32'h7FFFFFFF, 32'h80000000),
             cx(32'h7FFFFFFF, 32'h80000000), cx(0, 0), cx(0, 0), 0, 16);
    idle(20);
    checkOutput("floor_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] gapped input, W=(11585,11585)");
    setTwiddle(tw(11585, 11585), tw(11585, 11585));
    runFrame(cx(20, 0), cx(100, 0), cx(60, 0), cx(-29, -29), cx(-29, -29), 3, 16);
    idle(20);
    checkOutput("gap_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("gap_tail_run", 64'(last_run), 64'd24);

    $display("[TB] back-to-back frames, alternating twiddles");
    setTwiddle(tw(16384, 0), tw(0, -16384));
    runFrame(cx(100, 0), cx(20, 0), cx(60, 0), cx(40, 0), cx(0, -40), 0, 16);
    idle(16);
    runFrame(cx(100, 0), cx(20, 0), cx(60, 0), cx(40, 0), cx(0, -40), 0, 16);
    idle(20);
    checkOutput("b2b_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("b2b_run", 64'(last_run), 64'd64);
    checkOutput("b2b_overrun", 64'(overrun), 64'd0);

    $display("[TB] overrun injection during drain");
    setTwiddle(tw(16384, 0), tw(16384, 0));
    runFrame(cx(100, 0), cx(20, 0), cx(60, 0), cx(40, 0), cx(40, 0), 0, 16);
    idle(4);
    applyStimulus(cx(999, 999), cx(1, 1));
    idle(11);
    checkOutput("overrun_set", 64'(overrun), 64'd1);
    runFrame(cx(100, 0), cx(20, 0), cx(60, 0), cx(40, 0), cx(40, 0), 0, 16);
    idle(20);
    checkOutput("overrun_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("overrun_run", 64'(last_run), 64'd64);
    checkOutput("overrun_held", 64'(overrun), 64'd1);

    $display("[TB] reset mid-drain");
    runFrame(cx(100, 0), cx(20, 0), cx(60, 0), cx(40, 0), cx(40, 0), 0, 7);
    idle(7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_mid_valid", 64'(data_out_valid), 64'd0);
    checkOutput("rst_mid_overrun", 64'(overrun), 64'd0);
    checkOutput("rst_mid_data", data_out, 64'd0);
    checkOutput("rst_mid_pending", 64'(exp_q.size()), 64'd0);
    idle(2);
    runFrame(cx(100, 0), cx(20, 0), cx(60, 0), cx(40, 0), cx(40, 0), 0, 16);
    idle(20);
    checkOutput("post_rst_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("post_rst_run", 64'(last_run), 64'd32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bfly_16_1.md
# bfly_16_1

Radix-2 decimation-in-frequency butterfly stage that directly consumes the paired output of the 16-deep delay FIFO stage: `data_in1` is the delayed sample x1 and `data_in2` is the current sample x2. The sum (x1+x2)/2 is emitted immediately. The twiddled difference ((x1−x2)/2)·W^k is buffered internally and emitted in the 16 cycles after the last sum. The result is one contiguous 32-sample output stream per frame, which feeds the next FFT stage's delay FIFO. Arithmetic is signed fixed point. Twiddles are read from an external synchronous ROM addressed by this block.

## Interface
- `data_len`, default 32: width of each real/imag component.
- `pair_num`, default 16: x1/x2 pairs per frame.
- `pair_addr_len`, default 4: log2(`pair_num`).
- `tw_len`, default 16: width of each twiddle component, signed Q2.(`tw_len`−2); 1.0 = 16384.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `data_in1`  in  2·data_len  x1; real part in `[2·data_len−1:data_len]`, imag part in `[data_len−1:0]`.
- `data_in2`  in  2·data_len  x2; same packing.
- `data_in_valid`  in  1  pair valid.
- `tf_addr`  out  pair_addr_len  twiddle ROM address, equal to the current pair index k.
- `tf_data`  in  2·tw_len  twiddle {re, im}; valid one cycle after `tf_addr`.
- `data_out`  out  2·data_len  output sample; same packing as the inputs.
- `data_out_valid`  out  1  output valid.
- `data_out_sop`  out  1  high with the first sum of each frame.
- `overrun`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- There are two states, FILL and DRAIN. Reset enters FILL with pair counter k=0, read pointer r=0, and `overrun`=0.
- FILL, on `data_in_valid`=1:
  - Accept the pair and compute s = ((x1+x2) >>> 1) per component, using a (data_len+1)-bit intermediate and an arithmetic shift (floor).
  - Compute d = ((x1−x2) >>> 1) per component, with the same rule.
  - Register s to `data_out` and increment k.
  - Assert `data_out_sop` when the accepted k=0.
  - If the accepted k=`pair_num`−1, set k to 0 and go to DRAIN.
- FILL, on `data_in_valid`=0: k holds and no sum is output. Gaps inside a frame are legal.
- `tf_addr` = k, driven from the register.
- Twiddle product for pair k:
  - re = (dr·wr − di·wi) >>> (tw_len−2)
  - im = (dr·wi + di·wr) >>> (tw_len−2)
  - Products are data_len+tw_len bits; the sum adds one bit.
  - The result keeps the low data_len bits, wrapping with no saturation.
- Each product result is written to an internal `pair_num`-entry buffer at address k.
- DRAIN:
  - Read buffer entry r each cycle, r = 0..`pair_num`−1, and register it to `data_out` with `data_out_valid`=1.
  - After reading r=`pair_num`−1, set r to 0 and return to FILL.
- `data_in_valid`=1 in DRAIN: the pair is dropped, `overrun` is set, and k is unchanged.
- Reset mid-frame or mid-drain: state, k, r, the pipeline valids and all outputs clear on the next edge. Buffer contents are not cleared; they are don't-care because every entry is rewritten before it is read.

## Timing
- Reset values: `data_out`=0, `data_out_valid`=0, `data_out_sop`=0, `tf_addr`=0, `overrun`=0.
- Sum latency is 1: a pair accepted at edge t gives its sum on `data_out` after edge t+1.
- Difference pipeline for a pair accepted at edge t:
  - t+1: d and `tf_data` registered.
  - t+2: the four products registered.
  - t+3: add, shift and buffer write.
- Last pair accepted at edge T:
  - Sum 15 output at T+1.
  - DRAIN occupies T+1..T+16.
  - Diff 0..15 output at T+2..T+17, with no gap after sum 15.
  - Diff 15 is written at T+3, before it is read at T+16.
- The earliest legal next-frame pair is at edge T+17; its sum is output at T+18. A pair arriving in T+1..T+16 is an overrun.
- With the upstream delay FIFO's timing (16 fill cycles, then 16 pair cycles) this gives a seamless stream. Steady-state output is 32 valid cycles per 32-cycle frame.

## Test plan
- Basic butterfly with W=1: 16 pairs with x1=(100,0), x2=(20,0) and `tf_data`=(16384,0) → 16 outputs of (60,0), then 16 outputs of (40,0), contiguous. `data_out_sop` is high only on the first output.
- Twiddle −j: same inputs with `tf_data`=(0,−16384) → diffs = (0,−40).
- Floor rounding: x1=(−3,5), x2=(0,0), W=1 → sum=(−2,2) and diff=(−2,2).
- Gapped input: pairs with `data_in_valid` deasserted for 3 cycles between pairs 7 and 8 → sums are output only for valid pairs. DRAIN starts the cycle after sum 15 and `tf_addr` sequences 0..15.
- Back-to-back frames:
  - Second frame starting at T+17 → 64 consecutive valid outputs and `overrun`=0.
  - A pair injected at T+5 → `overrun`=1 and held; that pair is dropped and k is unchanged.
- Reset mid-drain: `rst` for one cycle at T+8 → the next edge shows `data_out_valid`=0 and `overrun`=0, the state is FILL, and a following clean frame produces correct output.
